wb_controller: RTL

- Writeback controller at the shared end of the scalar (MEM) and vector (last DSP stage) pipelines.
- Consumes the hazard unit's writeback selects and buffer commands.
- Arbitrates the single scalar-register-file write port and the single vector-register-file write port.
- Parks vector-pipeline results in small FIFOs when a newer scalar result must retire first, then drains them when commanded.

---
 rtl/wb_controller.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/wb_controller.sv
// Writeback controller: arbitrates the scalar- and vector-register-file write
// ports between the MEM-stage scalar result, the last-DSP-stage vector-pipe
// result and two small holding FIFOs that park vector-pipe results while a
// newer scalar result retires first.

// Holding FIFO for parked vector-pipe results ({address, data} entries).
// The FIFO qualifies push/pop itself and reports the error events, so the
// controller only has to decide when to request them.
module WbHoldFifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [4:0]               i_pushAddr,
  input  logic [DATA_W-1:0]        i_pushData,
  input  logic                     i_pop,
  output logic                     o_popValid,
  output logic [4:0]               o_headAddr,
  output logic [DATA_W-1:0]        o_headData,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflowEvt,
  output logic                     o_underflowEvt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [4:0]        r_addrMem [DEPTH];
  logic [DATA_W-1:0] r_dataMem [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic w_empty;
  logic w_full;
  logic w_doPop;
  logic w_doPush;

  // A pop frees the head slot in the same cycle, so a push into a full FIFO
  // is accepted whenever it is paired with a real pop.
  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign w_doPop  = i_pop & ~w_empty;
  assign w_doPush = i_push & (~w_full | w_doPop);

  assign o_popValid     = w_doPop;
  assign o_headAddr     = r_addrMem[r_head];
  assign o_headData     = r_dataMem[r_head];
  assign o_count        = r_count;
  assign o_overflowEvt  = i_push & w_full & ~w_doPop;
  assign o_underflowEvt = i_pop & w_empty;

  // Pointer and occupancy bookkeeping; power-of-two depth makes the pointers
  // wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_tail <= r_tail + 1'b1;
      if (w_doPop)  r_head <= r_head + 1'b1;
      if (w_doPush && !w_doPop)      r_count <= r_count + 1'b1;
      else if (w_doPop && !w_doPush) r_count <= r_count - 1'b1;
    end
  end

  // Entry storage; contents are only ever read while the count says they are
  // valid, so the array needs no reset.
  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_addrMem[r_tail] <= i_pushAddr;
      r_dataMem[r_tail] <= i_pushData;
    end
  end

endmodule

// Top-level writeback controller.
module wb_controller #(
  parameter int SDATA_W   = 32,
  parameter int VDATA_W   = 128,
  parameter int BUF_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_s_reg_wr_en,
  input  logic                         i_s_vec_wr_en,
  input  logic [4:0]                   i_s_wr_addr,
  input  logic [SDATA_W-1:0]           i_s_reg_data,
  input  logic [VDATA_W-1:0]           i_s_vec_data,
  input  logic                         i_v_reg_wr_en,
  input  logic                         i_v_vec_wr_en,
  input  logic [4:0]                   i_v_wr_addr,
  input  logic [SDATA_W-1:0]           i_v_reg_data,
  input  logic [VDATA_W-1:0]           i_v_vec_data,
  input  logic                         i_buffer_register,
  input  logic                         i_buffer_vector,
  input  logic                         i_buffer_register_sel,
  input  logic                         i_buffer_vector_sel,
  input  logic                         i_register_wb_sel,
  input  logic                         i_vector_wb_sel,
  output logic                         o_rf_wr_en,
  output logic [4:0]                   o_rf_wr_addr,
  output logic [SDATA_W-1:0]           o_rf_wr_data,
  output logic                         o_vf_wr_en,
  output logic [4:0]                   o_vf_wr_addr,
  output logic [VDATA_W-1:0]           o_vf_wr_data,
  output logic [$clog2(BUF_DEPTH):0]   o_reg_buf_count,
  output logic [$clog2(BUF_DEPTH):0]   o_vec_buf_count,
  output logic                         o_wb_conflict,
  output logic                         o_buf_overflow,
  output logic                         o_buf_underflow
);

  logic               w_regPop;
  logic               w_regDirect;
  logic               w_regScalar;
  logic               w_regPush;
  logic [4:0]         w_regHeadAddr;
  logic [SDATA_W-1:0] w_regHeadData;
  logic               w_regOvf;
  logic               w_regUnf;
  logic               w_regConflict;

  logic               w_vecPop;
  logic               w_vecDirect;
  logic               w_vecScalar;
  logic               w_vecPush;
  logic [4:0]         w_vecHeadAddr;
  logic [VDATA_W-1:0] w_vecHeadData;
  logic               w_vecOvf;
  logic               w_vecUnf;
  logic               w_vecConflict;

  // A direct vector write is suppressed when the same result is being parked,
  // so parking alongside a scalar write never counts as a conflict.
  assign w_regDirect = i_register_wb_sel & i_v_reg_wr_en & ~i_buffer_register;
  assign w_regScalar = i_s_reg_wr_en;
  assign w_regPush   = i_buffer_register & i_v_reg_wr_en;
  assign w_vecDirect = i_vector_wb_sel & i_v_vec_wr_en & ~i_buffer_vector;
  assign w_vecScalar = i_s_vec_wr_en;
  assign w_vecPush   = i_buffer_vector & i_v_vec_wr_en;

  assign w_regConflict = (w_regPop & w_regDirect) | (w_regPop & w_regScalar) |
                         (w_regDirect & w_regScalar);
  assign w_vecConflict = (w_vecPop & w_vecDirect) | (w_vecPop & w_vecScalar) |
                         (w_vecDirect & w_vecScalar);

  WbHoldFifo #(
    .DATA_W (SDATA_W),
    .DEPTH  (BUF_DEPTH)
  ) u_regFifo (
    .clk            (clk),
    .rst            (rst),
    .i_push         (w_regPush),
    .i_pushAddr     (i_v_wr_addr),
    .i_pushData     (i_v_reg_data),
    .i_pop          (i_buffer_register_sel),
    .o_popValid     (w_regPop),
    .o_headAddr     (w_regHeadAddr),
    .o_headData     (w_regHeadData),
    .o_count        (o_reg_buf_count),
    .o_overflowEvt  (w_regOvf),
    .o_underflowEvt (w_regUnf)
  );

  WbHoldFifo #(
    .DATA_W (VDATA_W),
    .DEPTH  (BUF_DEPTH)
  ) u_vecFifo (
    .clk            (clk),
    .rst            (rst),
    .i_push         (w_vecPush),
    .i_pushAddr     (i_v_wr_addr),
    .i_pushData     (i_v_vec_data),
    .i_pop          (i_buffer_vector_sel),
    .o_popValid     (w_vecPop),
    .o_headAddr     (w_vecHeadAddr),
    .o_headData     (w_vecHeadData),
    .o_count        (o_vec_buf_count),
    .o_overflowEvt  (w_vecOvf),
    .o_underflowEvt (w_vecUnf)
  );

  // Register-file write port: FIFO drain beats direct vector beats scalar.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_rf_wr_en   <= 1'b0;
      o_rf_wr_addr <= '0;
      o_rf_wr_data <= '0;
    end else begin
      o_rf_wr_en   <= w_regPop | w_regDirect | w_regScalar;
      if (w_regPop) begin
        o_rf_wr_addr <= w_regHeadAddr;
        o_rf_wr_data <= w_regHeadData;
      end else if (w_regDirect) begin
        o_rf_wr_addr <= i_v_wr_addr;
        o_rf_wr_data <= i_v_reg_data;
      end else if (w_regScalar) begin
        o_rf_wr_addr <= i_s_wr_addr;
        o_rf_wr_data <= i_s_reg_data;
      end else begin
        o_rf_wr_addr <= '0;
        o_rf_wr_data <= '0;
      end
    end
  end

  // Vector-file write port: same priority order with the vector sources.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_vf_wr_en   <= 1'b0;
      o_vf_wr_addr <= '0;
      o_vf_wr_data <= '0;
    end else begin
      o_vf_wr_en   <= w_vecPop | w_vecDirect | w_vecScalar;
      if (w_vecPop) begin
        o_vf_wr_addr <= w_vecHeadAddr;
        o_vf_wr_data <= w_vecHeadData;
      end else if (w_vecDirect) begin
        o_vf_wr_addr <= i_v_wr_addr;
        o_vf_wr_data <= i_v_vec_data;
      end else if (w_vecScalar) begin
        o_vf_wr_addr <= i_s_wr_addr;
        o_vf_wr_data <= i_s_vec_data;
      end else begin
        o_vf_wr_addr <= '0;
        o_vf_wr_data <= '0;
      end
    end
  end

  // Conflict pulse lines up with the write it affects; error flags are sticky
  // until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_wb_conflict   <= 1'b0;
      o_buf_overflow  <= 1'b0;
      o_buf_underflow <= 1'b0;
    end else begin
      o_wb_conflict   <= w_regConflict | w_vecConflict;
      o_buf_overflow  <= o_buf_overflow | w_regOvf | w_vecOvf;
      o_buf_underflow <= o_buf_underflow | w_regUnf | w_vecUnf;
    end
  end

endmodule
